// File: rtl/axi_slave_pkg.sv
// axi_slave_pkg: shared constants for the AXI slave memory.
//   - burst type encodings (FIXED / INCR / WRAP)
//   - response encodings (OKAY / SLVERR)
//   - write and read FSM state encodings
//   - wrap_ok(): legality test for a WRAP burst (length and alignment)
package axi_slave_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write FSM state encoding
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  // Read FSM state encoding
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  // A WRAP burst needs 2/4/8/16 beats and an 8-byte aligned start address.
  function automatic logic wrap_ok(input logic [7:0] len, input logic [2:0] lo);
    return (lo == 3'b000) &&
           (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_slave_mem_if.sv
// axi_slave_mem_if: AXI write/read channel bundle for the 64-bit slave memory.
//   AW channel: axi_awaddr, axi_awlen, axi_awburst, axi_awvalid / axi_awready
//   W  channel: axi_wdata, axi_wstrb, axi_wlast, axi_wvalid / axi_wready
//   B  channel: axi_bresp, axi_bvalid / axi_bready
//   AR channel: axi_araddr, axi_arlen, axi_arburst, axi_arvalid / axi_arready
//   R  channel: axi_rdata, axi_rresp, axi_rlast, axi_rvalid / axi_rready
// Modports: slave (memory side), master (initiator side).
interface axi_slave_mem_if #(parameter int AW = 32) ();

  logic [AW-1:0] axi_awaddr;
  logic [7:0]    axi_awlen;
  logic [1:0]    axi_awburst;
  logic          axi_awvalid;
  logic          axi_awready;

  logic [63:0]   axi_wdata;
  logic [7:0]    axi_wstrb;
  logic          axi_wlast;
  logic          axi_wvalid;
  logic          axi_wready;

  logic [1:0]    axi_bresp;
  logic          axi_bvalid;
  logic          axi_bready;

  logic [AW-1:0] axi_araddr;
  logic [7:0]    axi_arlen;
  logic [1:0]    axi_arburst;
  logic          axi_arvalid;
  logic          axi_arready;

  logic [63:0]   axi_rdata;
  logic [1:0]    axi_rresp;
  logic          axi_rlast;
  logic          axi_rvalid;
  logic          axi_rready;

  modport slave (
    input  axi_awaddr, axi_awlen, axi_awburst, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    output axi_wready,
    output axi_bresp, axi_bvalid,
    input  axi_bready,
    input  axi_araddr, axi_arlen, axi_arburst, axi_arvalid,
    output axi_arready,
    output axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    input  axi_rready
  );

  modport master (
    output axi_awaddr, axi_awlen, axi_awburst, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    input  axi_wready,
    input  axi_bresp, axi_bvalid,
    output axi_bready,
    output axi_araddr, axi_arlen, axi_arburst, axi_arvalid,
    input  axi_arready,
    input  axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    output axi_rready
  );

endinterface

// File: rtl/axi_burst_addr.sv
// axi_burst_addr: combinational next-beat address for one AXI burst.
//   addr_i  : current beat byte address
//   burst_i : burst type (FIXED / INCR / WRAP)
//   len_i   : beats minus one (sets the WRAP window size)
//   next_o  : byte address of the following beat (modulo 2^AW)
// Optional feature macro: AXI_SLAVE_WRAP_EN (without it WRAP steps like INCR).
module axi_burst_addr
  import axi_slave_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] addr_i,
  input  logic [1:0]    burst_i,
  input  logic [7:0]    len_i,
  output logic [AW-1:0] next_o
);

  logic [AW-1:0] incr;
  assign incr = addr_i + AW'(8);

`ifdef AXI_SLAVE_WRAP_EN
  // Legal wrap lengths make (len+1)*8-1 equal {len,3'b111}.
  logic [AW-1:0] mask;
  assign mask = AW'({len_i, 3'b111});

  always_comb begin
    next_o = incr;
    if (burst_i == BURST_FIXED)
      next_o = addr_i;
    else if (burst_i == BURST_WRAP)
      next_o = (addr_i & ~mask) | (incr & mask);
  end
`else
  logic unused_len;
  assign unused_len = ^len_i;

  always_comb begin
    next_o = incr;
    if (burst_i == BURST_FIXED)
      next_o = addr_i;
  end
`endif

endmodule

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI slave backed by DEPTH x 64-bit words of memory.
//   axi_aclk : sole clock, rising edge
//   rst      : synchronous active-high reset (memory contents untouched)
//   bus      : axi_slave_mem_if.slave (AW/W/B write side, AR/R read side)
// One write and one read burst in flight; the two FSMs are independent.
// Beats past DEPTH*8 bytes do not write, read as zero and report SLVERR.
// Optional feature macro: AXI_SLAVE_WRAP_EN compiles WRAP bursts in;
// otherwise burst type 10 behaves as INCR.
module axi_slave_mem
  import axi_slave_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DEPTH = 256
) (
  input  logic            axi_aclk,
  input  logic            rst,
  axi_slave_mem_if.slave  bus
);

  localparam int IDXW = $clog2(DEPTH);

  logic [63:0] mem_q [DEPTH];

  function automatic logic in_range(input logic [AW-1:0] a);
    return (a >> (IDXW + 3)) == '0;
  endfunction

  function automatic logic [IDXW-1:0] word_idx(input logic [AW-1:0] a);
    return a[IDXW+2:3];
  endfunction

  logic aw_bad, ar_bad;
`ifdef AXI_SLAVE_WRAP_EN
  assign aw_bad = (bus.axi_awburst == BURST_WRAP) && !wrap_ok(bus.axi_awlen, bus.axi_awaddr[2:0]);
  assign ar_bad = (bus.axi_arburst == BURST_WRAP) && !wrap_ok(bus.axi_arlen, bus.axi_araddr[2:0]);
`else
  assign aw_bad = 1'b0;
  assign ar_bad = 1'b0;
`endif

  // Write side: AW -> W beats -> B
  logic [1:0]    wstate_q, wstate_d;
  logic [AW-1:0] waddr_q, waddr_nxt;
  logic [1:0]    wburst_q;
  logic [7:0]    wlen_q, wcnt_q;
  logic          werr_q, wbad_q;
  logic          aw_hs, w_hs, w_last_beat;

  assign aw_hs       = (wstate_q == W_IDLE) && bus.axi_awvalid;
  assign w_hs        = (wstate_q == W_DATA) && bus.axi_wvalid;
  assign w_last_beat = (wcnt_q == 8'd0);

  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE:  if (aw_hs)                 wstate_d = W_DATA;
      W_DATA:  if (w_hs && w_last_beat)   wstate_d = W_RESP;
      W_RESP:  if (bus.axi_bready)        wstate_d = W_IDLE;
      default:                            wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      wstate_q <= W_IDLE;
      wcnt_q   <= 8'd0;
      werr_q   <= 1'b0;
      wbad_q   <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      if (aw_hs) begin
        wcnt_q <= bus.axi_awlen;
        werr_q <= aw_bad;
        wbad_q <= aw_bad;
      end else if (w_hs) begin
        wcnt_q <= wcnt_q - 8'd1;
        // Burst length comes from the counter; a disagreeing wlast only flags the error.
        if (!in_range(waddr_q) || (bus.axi_wlast != w_last_beat))
          werr_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (aw_hs) begin
      waddr_q  <= bus.axi_awaddr;
      wburst_q <= bus.axi_awburst;
      wlen_q   <= bus.axi_awlen;
    end else if (w_hs) begin
      waddr_q  <= waddr_nxt;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (!rst && w_hs && !wbad_q && in_range(waddr_q)) begin
      for (int b = 0; b < 8; b++)
        if (bus.axi_wstrb[b])
          mem_q[word_idx(waddr_q)][8*b +: 8] <= bus.axi_wdata[8*b +: 8];
    end
  end

  axi_burst_addr #(.AW(AW)) u_waddr (
    .addr_i  (waddr_q),
    .burst_i (wburst_q),
    .len_i   (wlen_q),
    .next_o  (waddr_nxt)
  );

  // Read side: AR -> R beats; rdata is registered from the address being loaded
  logic [0:0]    rstate_q;
  logic [AW-1:0] raddr_q, raddr_nxt, r_cur_addr;
  logic [1:0]    rburst_q, r_cur_burst;
  logic [7:0]    rlen_q, r_cur_len, rcnt_q;
  logic          rbad_q, r_cur_bad;
  logic [63:0]   rdata_q;
  logic [1:0]    rresp_q;
  logic          rlast_q;
  logic          ar_hs, r_hs, r_load, r_beat_ok;

  assign ar_hs  = (rstate_q == R_IDLE) && bus.axi_arvalid;
  assign r_hs   = (rstate_q == R_DATA) && bus.axi_rready;
  assign r_load = ar_hs || (r_hs && !rlast_q);

  // raddr_q holds the address of the next beat to load once a burst is running.
  always_comb begin
    r_cur_addr  = raddr_q;
    r_cur_burst = rburst_q;
    r_cur_len   = rlen_q;
    r_cur_bad   = rbad_q;
    if (rstate_q == R_IDLE) begin
      r_cur_addr  = bus.axi_araddr;
      r_cur_burst = bus.axi_arburst;
      r_cur_len   = bus.axi_arlen;
      r_cur_bad   = ar_bad;
    end
  end

  assign r_beat_ok = in_range(r_cur_addr) && !r_cur_bad;

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      rstate_q <= R_IDLE;
      rcnt_q   <= 8'd0;
      rbad_q   <= 1'b0;
      rlast_q  <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      if (ar_hs) begin
        rstate_q <= R_DATA;
        rcnt_q   <= bus.axi_arlen;
        rbad_q   <= ar_bad;
        rlast_q  <= (bus.axi_arlen == 8'd0);
      end else if (r_hs) begin
        if (rlast_q) begin
          rstate_q <= R_IDLE;
          rlast_q  <= 1'b0;
        end else begin
          rcnt_q   <= rcnt_q - 8'd1;
          rlast_q  <= (rcnt_q == 8'd1);
        end
      end
      // Non-blocking memory write means a same-cycle write is not seen here.
      if (r_load) begin
        rdata_q <= r_beat_ok ? mem_q[word_idx(r_cur_addr)] : '0;
        rresp_q <= r_beat_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (r_load)
      raddr_q <= raddr_nxt;
    if (ar_hs) begin
      rburst_q <= bus.axi_arburst;
      rlen_q   <= bus.axi_arlen;
    end
  end

  axi_burst_addr #(.AW(AW)) u_raddr (
    .addr_i  (r_cur_addr),
    .burst_i (r_cur_burst),
    .len_i   (r_cur_len),
    .next_o  (raddr_nxt)
  );

  assign bus.axi_awready = (wstate_q == W_IDLE);
  assign bus.axi_wready  = (wstate_q == W_DATA);
  assign bus.axi_bvalid  = (wstate_q == W_RESP);
  assign bus.axi_bresp   = werr_q ? RESP_SLVERR : RESP_OKAY;
  assign bus.axi_arready = (rstate_q == R_IDLE);
  assign bus.axi_rvalid  = (rstate_q == R_DATA);
  assign bus.axi_rdata   = rdata_q;
  assign bus.axi_rresp   = rresp_q;
  assign bus.axi_rlast   = rlast_q;

endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DEPTH, default 256, number of 64-bit memory words (power of two).
REQ-003 axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 axi_awaddr  in  AW  write burst start byte address.
REQ-006 axi_awlen  in  8  write beats minus one.
REQ-007 axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP.
REQ-008 axi_awvalid  in  1  write address valid.
REQ-009 axi_awready  out  1  write address accepted.
REQ-010 axi_wdata  in  64  write beat data.
REQ-011 axi_wstrb  in  8  byte enables, bit i covers wdata[8i+7:8i].
REQ-012 axi_wlast  in  1  initiator's last-beat marker.
REQ-013 axi_wvalid  in  1  write data valid.
REQ-014 axi_wready  out  1  write data accepted.
REQ-015 axi_bresp  out  2  00 OKAY, 10 SLVERR.
REQ-016 axi_bvalid  out  1  write response valid.
REQ-017 axi_bready  in  1  initiator accepts response.
REQ-018 axi_araddr / axi_arlen / axi_arburst / axi_arvalid  in  AW/8/2/1  read address channel, same meaning as AW.
REQ-019 axi_arready  out  1  read address accepted.
REQ-020 axi_rdata / axi_rresp / axi_rlast / axi_rvalid  out  64/2/1/1  read beat data, response, last, valid.
REQ-021 axi_rready  in  1  initiator accepts read beat.

Function
REQ-022 Handshake on any channel SHALL be valid && ready in the same cycle; outputs, once valid is asserted, SHALL remain stable until that handshake.
REQ-023 Write FSM SHALL have states W_IDLE (awready=1), W_DATA (wready=1), W_RESP (bvalid=1): AW handshake -> W_DATA next cycle; final beat handshake -> W_RESP next cycle; B handshake -> W_IDLE next cycle.
REQ-024 Read FSM SHALL have states R_IDLE (arready=1), R_DATA (rvalid=1): AR handshake -> R_DATA next cycle with first beat; each R handshake loads next beat next cycle; R handshake with rlast=1 -> R_IDLE.
REQ-025 Only one write and one read burst SHALL be outstanding; read and write FSMs SHALL run independently and concurrently.
REQ-026 Beat count SHALL be len+1 (1..256) held in an internal 8-bit down-counter; burst end is decided by the counter, not axi_wlast; axi_rlast SHALL be 1 exactly on beat len+1.
REQ-027 Word index SHALL be addr[log2(DEPTH)+2:3]; INCR adds 8 per beat; FIXED holds address; WRAP per REQ-034; address arithmetic SHALL be AW bits modulo 2^AW.
REQ-028 Write beat SHALL update only bytes whose wstrb bit is 1; wstrb=0x00 writes nothing.
REQ-029 Beat whose address >= DEPTH*8 SHALL not write memory, SHALL return rdata=0, and SHALL set that burst's response to SLVERR (bresp sticky; rresp per beat).
REQ-030 axi_wlast mismatching counter on any beat SHALL force bresp=SLVERR; data writes still occur.
REQ-031 Read and write to same word in same cycle: read beat SHALL return pre-write data.

Reset
REQ-032 When rst=1 at an edge: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=00, rresp=00, rdata=0, FSMs to W_IDLE/R_IDLE, in-flight bursts abandoned; memory contents SHALL be unchanged.

Configuration
REQ-033 Macro AXI_SLAVE_WRAP_EN SHALL compile WRAP support in or out.
REQ-034 With it: WRAP SHALL require len in {1,3,7,15} and an 8-byte-aligned address, and SHALL wrap within (len+1)*8-byte aligned window, otherwise SLVERR with no writes; without it: burst type 10 SHALL behave as INCR.

Structure
REQ-035 Package axi_slave_pkg SHALL hold burst-type and response constants and FSM state enums.
REQ-036 Sub-module axi_burst_addr (next-address generator for FIXED/INCR/WRAP) SHALL be instantiated once per direction.

Verification
REQ-037 AW addr=0x10 len=3 INCR, 4 beats data 0xA0..0xA3 wstrb=0xFF -> words 2..5 written, bvalid once, bresp=00.
REQ-038 AR addr=0x10 len=3 with rready toggling 1,0,1,0 -> rdata 0xA0..0xA3 held stable under stall, rlast only on 4th beat.
REQ-039 Write addr=DEPTH*8 len=0 -> no memory change, bresp=10; read same address -> rdata=0, rresp=10.
REQ-040 WRAP addr=0x18 len=3 -> beat words 3,0,1,2 with macro; 3,4,5,6 without.
REQ-041 rst asserted during beat 2 of an 8-beat write -> next cycle awready=1, wready=0, bvalid=0; beats already written retained.
